// File: rtl/stdp_pkg.sv
// Shared constants and direction encoding for the STDP weight-update engine.
package stdp_pkg;

    localparam int unsigned WEIGHT_W = 8;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned WINDOW   = 15;
    localparam int unsigned A_PLUS   = 16;
    localparam int unsigned A_MINUS  = 16;
    localparam int unsigned W_INIT   = 128;
    localparam int unsigned W_MAX    = 255;
    localparam int unsigned W_MIN    = 0;

    // Matches the ltp output bit: 1 = potentiation, 0 = depression.
    typedef enum logic {
        DirLtd = 1'b0,
        DirLtp = 1'b1
    } dir_e;

endpackage

// File: rtl/stdp_weight_update_if.sv
// Spike inputs, weight control and update outputs of the STDP engine.
interface stdp_weight_update_if #(
    parameter int unsigned WEIGHT_W = stdp_pkg::WEIGHT_W,
    parameter int unsigned CNT_W    = stdp_pkg::CNT_W
);

    logic                en;
    logic                pre_spike;
    logic                post_spike;
    logic                weight_load;
    logic [WEIGHT_W-1:0] weight_load_val;
    logic [WEIGHT_W-1:0] weight;
    logic [CNT_W-1:0]    time_diff;
    logic                ltp;
    logic                update_w_flag;

    modport master (
        output en,
        output pre_spike,
        output post_spike,
        output weight_load,
        output weight_load_val,
        input  weight,
        input  time_diff,
        input  ltp,
        input  update_w_flag
    );

    modport slave (
        input  en,
        input  pre_spike,
        input  post_spike,
        input  weight_load,
        input  weight_load_val,
        output weight,
        output time_diff,
        output ltp,
        output update_w_flag
    );

endinterface

// File: rtl/spike_timer.sv
// Spike trace: interval counter restarted by each spike, expiring after WINDOW cycles.
module spike_timer #(
    parameter int unsigned CNT_W  = 4,
    parameter int unsigned WINDOW = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             spike_i,
    input  logic             consume_i,
    output logic [CNT_W-1:0] timer_o,
    output logic             valid_o
);

    localparam logic [CNT_W-1:0] WinMax = CNT_W'(WINDOW);

    logic [CNT_W-1:0] timer_q, timer_d;
    logic             valid_q, valid_d;

    always_comb begin
        timer_d = timer_q;
        valid_d = valid_q;
        if (spike_i) begin
            timer_d = CNT_W'(1);
            valid_d = 1'b1;
        end else if (consume_i) begin
            // Nearest-neighbour pairing: a used trace cannot pair again.
            timer_d = '0;
            valid_d = 1'b0;
        end else if (valid_q && (timer_q < WinMax)) begin
            timer_d = timer_q + CNT_W'(1);
        end else if (timer_q == WinMax) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q <= '0;
            valid_q <= 1'b0;
        end else begin
            timer_q <= timer_d;
            valid_q <= valid_d;
        end
    end

    assign timer_o = timer_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/stdp_weight_update.sv
// STDP engine: pairs pre/post spikes (stage 1) and applies a shift-decayed,
// saturating weight change one cycle later (stage 2).
module stdp_weight_update #(
    parameter int unsigned WEIGHT_W = stdp_pkg::WEIGHT_W,
    parameter int unsigned CNT_W    = stdp_pkg::CNT_W,
    parameter int unsigned WINDOW   = stdp_pkg::WINDOW,
    parameter int unsigned A_PLUS   = stdp_pkg::A_PLUS,
    parameter int unsigned A_MINUS  = stdp_pkg::A_MINUS,
    parameter int unsigned W_INIT   = stdp_pkg::W_INIT,
    parameter int unsigned W_MAX    = stdp_pkg::W_MAX,
    parameter int unsigned W_MIN    = stdp_pkg::W_MIN
) (
    input  logic                 clk,
    input  logic                 rst,
    stdp_weight_update_if.slave  bus_io
);

    import stdp_pkg::*;

    localparam logic [WEIGHT_W:0]   APlusExt  = (WEIGHT_W + 1)'(A_PLUS);
    localparam logic [WEIGHT_W:0]   AMinusExt = (WEIGHT_W + 1)'(A_MINUS);
    localparam logic [WEIGHT_W:0]   WMaxExt   = (WEIGHT_W + 1)'(W_MAX);
    localparam logic [WEIGHT_W:0]   WMinExt   = (WEIGHT_W + 1)'(W_MIN);
    localparam logic [WEIGHT_W-1:0] WMax      = WEIGHT_W'(W_MAX);
    localparam logic [WEIGHT_W-1:0] WMin      = WEIGHT_W'(W_MIN);
    localparam logic [WEIGHT_W-1:0] WInit     = WEIGHT_W'(W_INIT);

    logic [CNT_W-1:0] pre_timer, post_timer;
    logic             pre_valid, post_valid;
    logic             pair_ltp, pair_ltd;

    // Stage-1 state: flag plus the interval/direction that stage 2 consumes.
    logic             flag_q, flag_d;
    logic [CNT_W-1:0] time_diff_q, time_diff_d;
    dir_e             ltp_q, ltp_d;

    logic [WEIGHT_W-1:0] weight_q, weight_d;
    logic [WEIGHT_W:0]   delta, w_ext, w_sum;
    logic [WEIGHT_W-1:0] w_up, w_dn;
    logic                w_under;

    spike_timer #(
        .CNT_W  (CNT_W),
        .WINDOW (WINDOW)
    ) u_pre_timer (
        .clk       (clk),
        .rst       (rst),
        .spike_i   (bus_io.pre_spike),
        .consume_i (pair_ltp),
        .timer_o   (pre_timer),
        .valid_o   (pre_valid)
    );

    spike_timer #(
        .CNT_W  (CNT_W),
        .WINDOW (WINDOW)
    ) u_post_timer (
        .clk       (clk),
        .rst       (rst),
        .spike_i   (bus_io.post_spike),
        .consume_i (pair_ltd),
        .timer_o   (post_timer),
        .valid_o   (post_valid)
    );

    // Coincident pre and post spikes never pair; both traces simply restart.
    assign pair_ltp = bus_io.en & bus_io.post_spike & ~bus_io.pre_spike & pre_valid;
    assign pair_ltd = bus_io.en & bus_io.pre_spike & ~bus_io.post_spike & post_valid;

    always_comb begin
        flag_d      = pair_ltp | pair_ltd;
        time_diff_d = time_diff_q;
        ltp_d       = ltp_q;
        if (pair_ltp) begin
            time_diff_d = pre_timer;
            ltp_d       = DirLtp;
        end else if (pair_ltd) begin
            time_diff_d = post_timer;
            ltp_d       = DirLtd;
        end
    end

    always_comb begin
        delta   = ((ltp_q == DirLtp) ? APlusExt : AMinusExt) >> (time_diff_q - CNT_W'(1));
        w_ext   = {1'b0, weight_q};
        w_sum   = w_ext + delta;
        w_up    = (w_sum > WMaxExt) ? WMax : w_sum[WEIGHT_W-1:0];
        w_under = w_ext < (WMinExt + delta);
        w_dn    = w_under ? WMin : (weight_q - delta[WEIGHT_W-1:0]);
    end

    // A load wins over stage 2 and discards the in-flight update.
    always_comb begin
        weight_d = weight_q;
        if (bus_io.weight_load) begin
            weight_d = bus_io.weight_load_val;
        end else if (flag_q) begin
            weight_d = (ltp_q == DirLtp) ? w_up : w_dn;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_q      <= 1'b0;
            time_diff_q <= '0;
            ltp_q       <= DirLtd;
            weight_q    <= WInit;
        end else begin
            flag_q      <= flag_d;
            time_diff_q <= time_diff_d;
            ltp_q       <= ltp_d;
            weight_q    <= weight_d;
        end
    end

    assign bus_io.weight        = weight_q;
    assign bus_io.time_diff     = time_diff_q;
    assign bus_io.ltp           = ltp_q;
    assign bus_io.update_w_flag = flag_q;

endmodule
